// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared widths and load-type encodings for the MEM/WB stage
package mem_wb_stage_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - load_align: lane extraction, extension and alignment check
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [DATA_W-1:0] memData,
    input  logic [1:0]        addr,
    input  logic [2:0]        loadType,
    output logic [DATA_W-1:0] alignedData,
    output logic              misalign
);
    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        case (addr)
            2'd0:    byteLane = memData[7:0];
            2'd1:    byteLane = memData[15:8];
            2'd2:    byteLane = memData[23:16];
            default: byteLane = memData[31:24];
        endcase
        halfLane = addr[1] ? memData[31:16] : memData[15:0];
    end

    // Encodings 5-7 fall through to the word path.
    always_comb begin
        alignedData = memData;
        misalign    = 1'b0;
        case (loadType)
            LD_B:    alignedData = {{24{byteLane[7]}}, byteLane};
            LD_BU:   alignedData = {24'd0, byteLane};
            LD_H: begin
                alignedData = {{16{halfLane[15]}}, halfLane};
                misalign    = addr[0];
            end
            LD_HU: begin
                alignedData = {16'd0, halfLane};
                misalign    = addr[0];
            end
            default: misalign = (addr != 2'd0);
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB register and writeback formatter with forwarding tap
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W     = mem_wb_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = mem_wb_stage_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  inValid,
    input  logic                  inRegWrite,
    input  logic                  inMemToReg,
    input  logic [REG_ADDR_W-1:0] inWriteReg,
    input  logic [DATA_W-1:0]     inAluResult,
    input  logic [DATA_W-1:0]     inMemData,
    input  logic [2:0]            inLoadType,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic                  wbValid,
    output logic                  misalign,
    output logic                  fwdValid,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]           retireCount,
`endif
    output logic [DATA_W-1:0]     fwdData
);
    import mem_wb_stage_pkg::*;

    logic [DATA_W-1:0] alignedData;
    logic              loadMisalign;
    logic [DATA_W-1:0] fmtData;
    logic              fmtMisalign;
    logic              fmtWriteOk;
    logic              fresh;

    load_align u_load_align (
        .memData     (inMemData),
        .addr        (inAluResult[1:0]),
        .loadType    (inLoadType),
        .alignedData (alignedData),
        .misalign    (loadMisalign)
    );

    // Alignment only matters for real loads; ALU results pass straight through.
    always_comb begin
        fmtData     = inMemToReg ? alignedData : inAluResult;
        fmtMisalign = inValid & inMemToReg & loadMisalign;
        fmtWriteOk  = inValid & inRegWrite & (inWriteReg != '0) & ~fmtMisalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbValid   <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            misalign  <= 1'b0;
            fwdValid  <= 1'b0;
            fresh     <= 1'b0;
        end else if (flush) begin
            wbValid   <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            misalign  <= 1'b0;
            fwdValid  <= 1'b0;
            fresh     <= 1'b0;
        end else if (stall) begin
            fresh <= 1'b0;
        end else begin
            wbValid   <= inValid;
            writeReg  <= inWriteReg;
            writeData <= fmtData;
            misalign  <= fmtMisalign;
            fwdValid  <= fmtWriteOk;
            fresh     <= inValid;
        end
    end

    // fwdValid already folds in valid, raw write enable, $0 and misalign;
    // fresh limits the register-file write to the first cycle of the entry.
    assign regWrite = fwdValid & fresh;
    assign fwdData  = writeData;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retireCount <= 32'd0;
        end else if (wbValid & fresh) begin
            retireCount <= retireCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, inValid = 1'b0, inRegWrite = 1'b0, inMemToReg = 1'b0;
    logic [4:0]  inWriteReg = '0;
    logic [31:0] inAluResult = '0, inMemData = '0;
    logic [2:0]  inLoadType = '0;
    logic        regWrite, wbValid, misalign, fwdValid;
    logic [4:0]  writeReg;
    logic [31:0] writeData, fwdData;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCount;
`endif

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .inValid(inValid),
        .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .inWriteReg(inWriteReg),
        .inAluResult(inAluResult), .inMemData(inMemData), .inLoadType(inLoadType),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .wbValid(wbValid),
        .misalign(misalign), .fwdValid(fwdValid),
`ifdef WB_RETIRE_CNT_EN
        .retireCount(retireCount),
`endif
        .fwdData(fwdData)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        v;
        logic        mis;
        logic        fv;
        logic [31:0] fd;
        logic [31:0] cnt;
    } exp_t;

    exp_t expQ[$];

    // Reference model: one WB "entry" plus a count of retirements.
    bit          mValid, mFresh, mMis, mWriteOk;
    bit [4:0]    mReg;
    bit [31:0]   mData, mCnt;

    function automatic bit [31:0] refData(bit [31:0] mem, bit [31:0] alu, int lt);
        int a = alu % 4;
        int b = (mem >> (8 * a)) % 256;
        int h = (mem >> (16 * (a / 2))) % 65536;
        case (lt)
            1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            2: return 32'(b);
            3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            4: return 32'(h);
            default: return mem;
        endcase
    endfunction

    function automatic bit refMis(bit [31:0] alu, int lt);
        int a = alu % 4;
        if (lt == 1 || lt == 2) return 1'b0;
        if (lt == 3 || lt == 4) return (a % 2) != 0;
        return a != 0;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.rw  = mWriteOk && mFresh;
        e.rd  = mReg;
        e.wd  = mData;
        e.v   = mValid;
        e.mis = mMis;
        e.fv  = mWriteOk;
        e.fd  = mData;
        e.cnt = mCnt;
        return e;
    endfunction

    function automatic void modelReset();
        mValid = 0; mFresh = 0; mMis = 0; mWriteOk = 0; mReg = 0; mData = 0; mCnt = 0;
    endfunction

    task automatic step(bit f, bit s, bit v, bit rw, bit m2r, bit [4:0] rd,
                        bit [31:0] alu, bit [31:0] mem, bit [2:0] lt);
        @(negedge clk);
        flush = f; stall = s; inValid = v; inRegWrite = rw; inMemToReg = m2r;
        inWriteReg = rd; inAluResult = alu; inMemData = mem; inLoadType = lt;
        if (mValid && mFresh) mCnt = mCnt + 1;
        if (f) begin
            mValid = 0; mFresh = 0; mMis = 0; mWriteOk = 0; mReg = 0; mData = 0;
        end else if (s) begin
            mFresh = 0;
        end else begin
            mValid   = v;
            mFresh   = v;
            mReg     = rd;
            mData    = m2r ? refData(mem, alu, int'(lt)) : alu;
            mMis     = v && m2r && refMis(alu, int'(lt));
            mWriteOk = v && rw && rd != 0 && !mMis;
        end
        expQ.push_back(snapshot());
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: every cycle after the capture edge, pop and compare.
    always @(posedge clk) begin
        #2;
        if (expQ.size() > 0) begin
            exp_t e, a;
            e = expQ.pop_front();
            a = '0;
            a.rw = regWrite; a.rd = writeReg; a.wd = writeData; a.v = wbValid;
            a.mis = misalign; a.fv = fwdValid; a.fd = fwdData;
`ifdef WB_RETIRE_CNT_EN
            a.cnt = retireCount;
`else
            a.cnt = e.cnt;
`endif
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL scoreboard act=%h exp=%h", a, e);
            end
        end
    end

    initial begin
        modelReset();
        #1;
        check("reset_wbValid", {31'd0, wbValid}, 32'd0);
        check("reset_writeData", writeData, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte/halfword extraction at address offset 2.
        step(0, 0, 1, 1, 1, 5'd7, 32'h1000_0002, 32'h80FF_7F01, 3'd1);
        settle();
        check("lb_data", writeData, 32'hFFFF_FFFF);
        check("lb_regWrite", {31'd0, regWrite}, 32'd1);
        step(0, 0, 1, 1, 1, 5'd7, 32'h1000_0002, 32'h80FF_7F01, 3'd2);
        settle();
        check("lbu_data", writeData, 32'h0000_00FF);
        step(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        settle();
        check("lbu_pulse_once", {31'd0, regWrite}, 32'd0);
        step(0, 0, 1, 1, 1, 5'd8, 32'h1000_0002, 32'h80FF_7F01, 3'd3);
        settle();
        check("lh_data", writeData, 32'hFFFF_80FF);

        // addi $5 then three stall cycles.
        step(0, 0, 1, 1, 0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 3'd0);
        settle();
        check("stall0_regWrite", {31'd0, regWrite}, 32'd1);
        check("stall0_fwd", {31'd0, fwdValid}, 32'd1);
        check("stall0_fwdData", fwdData, 32'h1234);
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 1, 1, 0, 5'd9, 32'h5555, 32'h0, 3'd0);
            settle();
            check($sformatf("stall%0d_regWrite", i), {31'd0, regWrite}, 32'd0);
            check($sformatf("stall%0d_fwd", i), {31'd0, fwdValid}, 32'd1);
            check($sformatf("stall%0d_fwdData", i), fwdData, 32'h1234);
        end

        // Suppressed writes.
        step(0, 0, 1, 1, 0, 5'd0, 32'hAAAA, 32'h0, 3'd0);
        settle();
        check("r0_regWrite", {31'd0, regWrite}, 32'd0);
        check("r0_fwdValid", {31'd0, fwdValid}, 32'd0);
        step(0, 0, 1, 1, 1, 5'd3, 32'h2001, 32'h1234_5678, 3'd3);
        settle();
        check("lh_mis", {31'd0, misalign}, 32'd1);
        check("lh_mis_regWrite", {31'd0, regWrite}, 32'd0);
        step(0, 0, 1, 1, 1, 5'd3, 32'h2002, 32'h1234_5678, 3'd0);
        settle();
        check("lw_mis", {31'd0, misalign}, 32'd1);

        // Flush beats stall; invalid entries never write.
        step(1, 1, 1, 1, 0, 5'd4, 32'h77, 32'h0, 3'd0);
        settle();
        check("flush_wbValid", {31'd0, wbValid}, 32'd0);
        check("flush_regWrite", {31'd0, regWrite}, 32'd0);
        step(0, 0, 0, 1, 0, 5'd4, 32'h77, 32'h0, 3'd0);
        settle();
        check("invalid_regWrite", {31'd0, regWrite}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom, 3'($urandom));
        end
        settle();

        // Asynchronous reset while an entry is stalled.
        step(0, 0, 1, 1, 0, 5'd6, 32'h4321, 32'h0, 3'd0);
        settle();
        stall = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_wbValid", {31'd0, wbValid}, 32'd0);
        check("arst_fwdValid", {31'd0, fwdValid}, 32'd0);
        check("arst_writeData", writeData, 32'd0);
        check("arst_writeReg", {27'd0, writeReg}, 32'd0);
        modelReset();
        settle();
        check("arst_hold_regWrite", {31'd0, regWrite}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 0, 5'(i + 1), 32'(i), 32'h0, 3'd0);
            step(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
            step(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        end
        settle();
        check("retire_five", retireCount, 32'd5);
        force dut.retireCount = 32'hFFFF_FFFF;
        #1;
        release dut.retireCount;
        mCnt = 32'hFFFF_FFFF;
        step(0, 0, 1, 1, 0, 5'd2, 32'h9, 32'h0, 3'd0);
        step(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        settle();
        check("retire_wrap", retireCount, 32'd0);
`endif

        settle();
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter that feeds the register file's writeReg, writeData and regWrite inputs.
- Captures the MEM-stage result, sign- or zero-extends and aligns load data, and suppresses illegal writes.
- Provides a forwarding tap for the EX-stage bypass muxes.
- One-cycle latency: a value captured at a posedge is written by the register file at the following negedge.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the current WB entry.
- flush  in  1  load a bubble on the next edge.
- inValid  in  1  the MEM-stage entry is a real instruction.
- inRegWrite  in  1  the instruction writes a GPR.
- inMemToReg  in  1  1 selects load data, 0 selects the ALU result.
- inWriteReg  in  5  destination register index.
- inAluResult  in  32  ALU result; also the effective address for loads.
- inMemData  in  32  raw word read from data memory.
- inLoadType  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; 5-7 are treated as lw.
- regWrite  out  1  write enable to the register file.
- writeReg  out  5  destination index.
- writeData  out  32  formatted write data.
- wbValid  out  1  the WB entry holds a real instruction.
- misalign  out  1  the WB entry is a load whose address violates its alignment.
- fwdValid  out  1  forwarding tap is usable (= wbValid & wbRegWriteRaw & writeReg!=0 & ~misalign).
- fwdData  out  32  equals writeData.

Behaviour:
- Reset (async, rst_n=0): wbValid, regWrite, misalign, fwdValid = 0; writeReg = 0; writeData = 0; fresh = 0.
- Next-state priority per posedge: flush > stall > load.
  - flush: entry becomes a bubble (wbValid=0, all write controls 0); data fields are don't-care but cleared to 0.
  - stall (no flush): every register holds its value and fresh is cleared to 0.
  - Otherwise: load the formatted inputs and set fresh = inValid.
- Formatting is done before the register, so outputs are pure flops.
  - Byte select: inAluResult[1:0] picks byte 0..3; byte 0 is bits [7:0] (little-endian lanes).
  - Halfword select: inAluResult[1] picks [15:0] or [31:16].
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - Applied only when inMemToReg=1; otherwise writeData = inAluResult.
- misalign = 1 for a halfword load with addr[0]=1, or an lw with addr[1:0]!=0. A misaligned entry never writes.
- regWrite = wbValid & fresh & wbRegWriteRaw & (writeReg!=0) & ~misalign.
  - The write pulses exactly once per instruction, even across stall cycles.
  - Writes to $0 are never issued.
- fwdValid ignores fresh. Forwarding stays valid for the whole stall.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall clears the entry immediately (asynchronous).
- inValid=0 with inRegWrite=1: regWrite stays 0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retireCount [31:0].
  - Increments on every cycle where wbValid & fresh.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset value is 0.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package holds:
  - load-type constants LD_W=0, LD_B=1, LD_BU=2, LD_H=3, LD_HU=4;
  - DATA_W and REG_ADDR_W defaults.
- One natural sub-module: load_align, a combinational extractor taking data, addr[1:0] and loadType, returning the aligned word and the misalign flag.
- Everything else lives in mem_wb_stage.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> all outputs 0 immediately.
- Byte loads: inMemData=0x80FF7F01, addr=0x...02, lb -> writeData=0xFFFFFFFF, regWrite pulses 1 cycle. Same with lbu -> 0x000000FF. Same with lh at addr 0x...02 -> 0xFFFF80FF.
- Stall: inject an addi to $5 = 0x1234, then hold stall=1 for 3 cycles -> regWrite high only in the first cycle; fwdValid=1 and fwdData=0x1234 in all 4 cycles.
- Suppressed writes:
  - Write to $0 -> regWrite=0, fwdValid=0.
  - lh at addr 0x...01 -> misalign=1, regWrite=0.
  - lw at addr 0x...02 -> misalign=1.
- Flush and bubbles:
  - flush=1 and stall=1 together -> next cycle wbValid=0, regWrite=0.
  - inValid=0 with inRegWrite=1 -> no write.
- WB_RETIRE_CNT_EN: 5 valid instructions with 2 stall cycles between them -> retireCount=5. Preload near wrap via forced state -> 0xFFFFFFFF rolls to 0.
